// File: rtl/sdram_arbiter.sv
// Two-requester Avalon-MM arbiter in front of an SDRAM controller: round-robin grant
// with a per-grant transfer limit, plus a tag FIFO that routes in-order read data back.
module sdram_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int HOLD_MAX = 4,
  parameter int MAX_OUT  = 4
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [ADDR_W-1:0]          m0_address,
  input  logic                       m0_read,
  input  logic                       m0_write,
  input  logic [DATA_W-1:0]          m0_writedata,
  output logic                       m0_waitrequest,
  output logic [DATA_W-1:0]          m0_readdata,
  output logic                       m0_readdatavalid,
  input  logic [ADDR_W-1:0]          m1_address,
  input  logic                       m1_read,
  input  logic                       m1_write,
  input  logic [DATA_W-1:0]          m1_writedata,
  output logic                       m1_waitrequest,
  output logic [DATA_W-1:0]          m1_readdata,
  output logic                       m1_readdatavalid,
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_read,
  output logic                       avm_write,
  output logic [DATA_W-1:0]          avm_writedata,
  input  logic                       avm_waitrequest,
  input  logic [DATA_W-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid,
  output logic [1:0]                 grant,
  output logic [$clog2(MAX_OUT):0]   rd_outstanding,
  output logic                       rdv_error
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int PW = $clog2(MAX_OUT);
  localparam int HW = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT0 = 2'd1;
  localparam logic [1:0] S_GRANT1 = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               last_q, last_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [MAX_OUT-1:0] tag_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic               err_q;

  logic req0_s, req1_s, sel_read_s, sel_write_s, stall_s, accept_s, push_s, pop_s, head_s;

  // Command multiplexer; the read stall only looks at the registered count.
  always_comb begin
    req0_s        = m0_read | m0_write;
    req1_s        = m1_read | m1_write;
    sel_read_s    = 1'b0;
    sel_write_s   = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (state_q)
      S_GRANT0: begin
        sel_read_s    = m0_read;
        sel_write_s   = m0_write & ~m0_read;
        avm_address   = m0_address;
        avm_writedata = m0_writedata;
      end
      S_GRANT1: begin
        sel_read_s    = m1_read;
        sel_write_s   = m1_write & ~m1_read;
        avm_address   = m1_address;
        avm_writedata = m1_writedata;
      end
      default: begin
        sel_read_s  = 1'b0;
        sel_write_s = 1'b0;
      end
    endcase
    stall_s   = sel_read_s & (cnt_q == CW'(MAX_OUT));
    avm_read  = sel_read_s & ~stall_s;
    avm_write = sel_write_s;
    accept_s  = (avm_read | avm_write) & ~avm_waitrequest;
    push_s    = accept_s & avm_read;
    pop_s     = avm_readdatavalid & (cnt_q != CW'(0));
    head_s    = tag_q[rd_ptr_q];

    m0_waitrequest   = ~((state_q == S_GRANT0) & ~avm_waitrequest & ~stall_s);
    m1_waitrequest   = ~((state_q == S_GRANT1) & ~avm_waitrequest & ~stall_s);
    m0_readdatavalid = pop_s & ~head_s;
    m1_readdatavalid = pop_s & head_s;
    m0_readdata      = avm_readdata;
    m1_readdata      = avm_readdata;
    grant            = {state_q == S_GRANT1, state_q == S_GRANT0};
    rd_outstanding   = cnt_q;
    rdv_error        = err_q;
  end

  // Grant FSM: last_q holds the id of the requester most recently released.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        hold_d = '0;
        if (req0_s && req1_s) begin
          state_d = last_q ? S_GRANT0 : S_GRANT1;
        end else if (req0_s) begin
          state_d = S_GRANT0;
        end else if (req1_s) begin
          state_d = S_GRANT1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (!((state_q == S_GRANT0) ? req0_s : req1_s)) begin
          state_d = S_IDLE;
          last_d  = (state_q == S_GRANT1);
        end else if (accept_s) begin
          hold_d = hold_q + HW'(1);
          if (hold_q == HW'(HOLD_MAX - 1)) begin
            state_d = S_IDLE;
            last_d  = (state_q == S_GRANT1);
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // State, read-tag FIFO and sticky error registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      hold_q   <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      if (push_s) begin
        tag_q[wr_ptr_q] <= (state_q == S_GRANT1);
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (avm_readdatavalid && (cnt_q == CW'(0))) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_sdram_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int HOLD_MAX = 4;
  localparam int MAX_OUT = 4;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address, avm_address;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, avm_writedata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, avm_readdata;
  logic avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [1:0] grant;
  logic [$clog2(MAX_OUT):0] rd_outstanding;
  logic rdv_error;

  int checks = 0;
  int failures = 0;

  // reference model: owner -1 means nobody holds the bus
  int m_owner, m_last, m_hold;
  int m_q[$];
  bit m_err;

  logic e_read, e_write, e_wait0, e_wait1, e_rdv0, e_rdv1, e_accept;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [1:0] e_grant;

  always #5 clk_clk = ~clk_clk;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX), .MAX_OUT(MAX_OUT)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .grant(grant), .rd_outstanding(rd_outstanding), .rdv_error(rdv_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_hold  = 0;
    m_q.delete();
    m_err   = 1'b0;
  endtask

  task automatic predict();
    logic r, w, stall;
    r = 1'b0; w = 1'b0;
    e_addr = '0; e_wdata = '0;
    if (m_owner == 0) begin
      r = m0_read; w = m0_write && !m0_read; e_addr = m0_address; e_wdata = m0_writedata;
    end else if (m_owner == 1) begin
      r = m1_read; w = m1_write && !m1_read; e_addr = m1_address; e_wdata = m1_writedata;
    end
    stall    = r && (m_q.size() == MAX_OUT);
    e_read   = r && !stall;
    e_write  = w;
    e_accept = (e_read || e_write) && !avm_waitrequest;
    e_wait0  = !(m_owner == 0 && !avm_waitrequest && !stall);
    e_wait1  = !(m_owner == 1 && !avm_waitrequest && !stall);
    e_grant  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_rdv0   = avm_readdatavalid && m_q.size() > 0 && m_q[0] == 0;
    e_rdv1   = avm_readdatavalid && m_q.size() > 0 && m_q[0] == 1;
  endtask

  task automatic compare_all();
    predict();
    check("grant", 32'(grant), 32'(e_grant));
    check("avm_read", 32'(avm_read), 32'(e_read));
    check("avm_write", 32'(avm_write), 32'(e_write));
    check("avm_address", 32'(avm_address), 32'(e_addr));
    check("avm_writedata", 32'(avm_writedata), 32'(e_wdata));
    check("m0_waitrequest", 32'(m0_waitrequest), 32'(e_wait0));
    check("m1_waitrequest", 32'(m1_waitrequest), 32'(e_wait1));
    check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(e_rdv0));
    check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(e_rdv1));
    check("m0_readdata", 32'(m0_readdata), 32'(avm_readdata));
    check("m1_readdata", 32'(m1_readdata), 32'(avm_readdata));
    check("rd_outstanding", 32'(rd_outstanding), 32'(m_q.size()));
    check("rdv_error", 32'(rdv_error), 32'(m_err));
  endtask

  task automatic model_clock();
    bit req0, req1, mine;
    predict();
    req0 = m0_read || m0_write;
    req1 = m1_read || m1_write;
    if (avm_readdatavalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (e_accept && e_read) m_q.push_back(m_owner);
    if (m_owner < 0) begin
      m_hold = 0;
      if (req0 && req1) m_owner = (m_last == 1) ? 0 : 1;
      else if (req0) m_owner = 0;
      else if (req1) m_owner = 1;
    end else begin
      mine = (m_owner == 0) ? req0 : req1;
      if (!mine) begin
        m_last = m_owner; m_owner = -1;
      end else if (e_accept) begin
        m_hold++;
        if (m_hold == HOLD_MAX) begin
          m_last = m_owner; m_owner = -1;
        end
      end
    end
  endtask

  // inputs are changed 1 time unit after a rising edge, outputs sampled at the falling edge
  task automatic cycle();
    @(negedge clk_clk);
    compare_all();
    @(posedge clk_clk);
    model_clock();
    #1;
  endtask

  task automatic quiet();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
  endtask

  initial begin
    quiet();
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0; avm_readdata = '0;
    reset_reset_n = 1'b0;
    model_reset();
    #3;
    compare_all();
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;

    // single write from m0
    m0_write = 1'b1; m0_address = 25'h10; m0_writedata = 16'hBEEF;
    cycle();
    check("wr_grant_pending", 32'(grant), 32'h1);
    check("wr_avm_write", 32'(avm_write), 32'h1);
    check("wr_avm_address", 32'(avm_address), 32'h10);
    check("wr_avm_writedata", 32'(avm_writedata), 32'hBEEF);
    check("wr_m0_wait", 32'(m0_waitrequest), 32'h0);
    cycle();
    m0_write = 1'b0;
    cycle();
    check("wr_back_idle", 32'(grant), 32'h0);
    cycle();

    // m0 read then m1 read, returned in order
    m0_read = 1'b1; m0_address = 25'h20;
    cycle(); cycle();
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 25'h30;
    cycle(); cycle(); cycle();
    m1_read = 1'b0;
    cycle();
    check("two_outstanding", 32'(rd_outstanding), 32'h2);
    avm_readdatavalid = 1'b1; avm_readdata = 16'h1111;
    #1;
    check("ret0_valid", 32'(m0_readdatavalid), 32'h1);
    check("ret0_not_m1", 32'(m1_readdatavalid), 32'h0);
    check("ret0_data", 32'(m0_readdata), 32'h1111);
    cycle();
    avm_readdata = 16'h2222;
    #1;
    check("ret1_valid", 32'(m1_readdatavalid), 32'h1);
    check("ret1_data", 32'(m1_readdata), 32'h2222);
    cycle();
    avm_readdatavalid = 1'b0;
    cycle();
    check("drained", 32'(rd_outstanding), 32'h0);

    // stray return with nothing outstanding
    avm_readdatavalid = 1'b1; avm_readdata = 16'h5A5A;
    cycle();
    avm_readdatavalid = 1'b0;
    cycle(); cycle();
    check("stray_err_sticky", 32'(rdv_error), 32'h1);
    do_reset();
    check("err_cleared", 32'(rdv_error), 32'h0);

    // both read continuously with slow returns: hold limit, alternation, stall
    m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    check("stall_full", 32'(rd_outstanding), 32'(MAX_OUT));
    avm_readdatavalid = 1'b1;
    for (int i = 0; i < 24; i++) cycle();
    quiet();
    avm_readdatavalid = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    avm_readdatavalid = 1'b0;
    cycle();

    // reset during GRANT1 with two reads outstanding
    do_reset();
    m1_read = 1'b1;
    cycle(); cycle(); cycle();
    check("pre_reset_out", 32'(rd_outstanding), 32'h2);
    reset_reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
    m1_read = 1'b0;
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    cycle();
    avm_readdatavalid = 1'b1;
    cycle();
    avm_readdatavalid = 1'b0;
    cycle();
    check("post_reset_stray", 32'(rdv_error), 32'h1);
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      m0_read  = 1'($urandom_range(2, 0) == 0);
      m0_write = 1'($urandom_range(4, 0) == 0);
      m1_read  = 1'($urandom_range(2, 0) == 0);
      m1_write = 1'($urandom_range(4, 0) == 0);
      m0_address = ADDR_W'($urandom); m1_address = ADDR_W'($urandom);
      m0_writedata = DATA_W'($urandom); m1_writedata = DATA_W'($urandom);
      avm_readdata = DATA_W'($urandom);
      avm_waitrequest = 1'($urandom_range(3, 0) == 0);
      if (m_q.size() > 0) avm_readdatavalid = 1'($urandom_range(1, 0));
      else avm_readdatavalid = 1'($urandom_range(199, 0) == 0);
      cycle();
      if (i == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
